magphase_fanout: RTL and testbench

Parametrised successor to the envelope output stage. Takes one stream of magnitude/phase samples with a CHDR header on `i_tuser` and fans it out to `NUM_OUT` independently buffered output streams. Each output has its own run-time mode, next destination and munged SID. Sits between the CORDIC magphase stage and the per-port `chdr_framer` instances inside the `noc_block` wrapper.

---
 rtl/magphase_fanout_pkg.sv | 33 +++
 rtl/magphase_fanout_fifo.sv | 51 +++++
 rtl/magphase_fanout_lane.sv | 109 ++++++++++
 rtl/magphase_fanout.sv | 122 ++++++++++++
 tb/tb_magphase_fanout.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/magphase_fanout_pkg.sv
// Purpose: shared mode encodings, settings offsets and CHDR header field positions.
// Latency: n/a (types, constants and a combinational header helper only).
// Backpressure: n/a.
package magphase_fanout_pkg;

  typedef enum logic [1:0] {
    MODE_MAG      = 2'd0,
    MODE_PHASE    = 2'd1,
    MODE_MAGPHASE = 2'd2,
    MODE_OFF      = 2'd3
  } mode_e;

  localparam int SR_NEXT_DST_OFS = 0;
  localparam int SR_MODE_OFS     = 4;

  localparam int HDR_W       = 128;
  // SID occupies [95:64]: source endpoint in the upper half, destination in the lower.
  localparam int SID_SRC_LSB = 80;
  localparam int SID_DST_LSB = 64;

  // Rewrites the SID: source keeps the upstream destination's upper 12 bits and
  // takes the lane index as its low nibble; destination becomes this lane's next hop.
  function automatic logic [HDR_W-1:0] munge_hdr(input logic [HDR_W-1:0] hdr,
                                                 input logic [15:0]      next_dst,
                                                 input logic [3:0]       lane);
    logic [HDR_W-1:0] h;
    h = hdr;
    h[SID_SRC_LSB +: 16] = {hdr[SID_DST_LSB+4 +: 12], lane};
    h[SID_DST_LSB +: 16] = next_dst;
    return h;
  endfunction

endpackage

// File: rtl/magphase_fanout_fifo.sv
// Purpose: generic synchronous FIFO, depth 2**AW, first-word-fall-through read port.
// Latency: a word pushed at edge N is visible on dat_o after edge N.
// Backpressure: caller must not push when full unless popping in the same cycle.
module magphase_fanout_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [W-1:0]  dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  dat_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0]  mem_q [0:(1<<AW)-1];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;

  // Storage array: contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= dat_i;
  end

  // Occupancy: a simultaneous push and pop leaves the count unchanged, even when full.
  always_comb begin
    count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  assign dat_o   = mem_q[rptr_q];
  assign full_o  = count_q[AW];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/magphase_fanout_lane.sv
// Purpose: one output lane: mode formatting, SID munge, data and header FIFOs, output handshake.
// Latency: beat accepted at edge N appears on tvalid_o after edge N+1 (one staging register).
// Backpressure: dat_rdy_o drops once FIFO plus staging register hold 2**DATA_AWIDTH beats.
module magphase_fanout_lane
  import magphase_fanout_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int DATA_AWIDTH = 5,
  parameter int HDR_AWIDTH  = 2,
  parameter int LANE_IDX    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode_i,
  input  logic [15:0]          next_dst_i,
  input  logic                 push_i,
  input  logic                 first_i,
  input  logic [2*WIDTH-1:0]   dat_i,
  input  logic                 last_i,
  input  logic [HDR_W-1:0]     hdr_i,
  output logic                 dat_rdy_o,
  output logic                 hdr_rdy_o,
  output logic [2*WIDTH-1:0]   tdata_o,
  output logic                 tlast_o,
  output logic                 tvalid_o,
  output logic [HDR_W-1:0]     tuser_o,
  input  logic                 tready_i
);

  localparam logic [DATA_AWIDTH:0] DDEPTH = {1'b1, {DATA_AWIDTH{1'b0}}};

  logic [WIDTH:0]       mag_inc;
  logic [WIDTH-1:0]     mag_half, mag_rc;
  logic [2*WIDTH-1:0]   fmt_dat;
  logic                 stage_vld_q, stage_vld_d;
  logic [2*WIDTH:0]     stage_dat_q, stage_dat_d;
  logic [2*WIDTH:0]     dhead;
  logic                 dempty, dfull_unused, dpop;
  logic [DATA_AWIDTH:0] dcount;
  logic [HDR_W-1:0]     hhead;
  logic                 hempty, hfull, hpop;
  logic [HDR_AWIDTH:0]  hcount_unused;

  // Round the unsigned magnitude to half scale and clamp into the signed positive range.
  always_comb begin
    mag_inc  = {1'b0, dat_i[2*WIDTH-1:WIDTH]} + (WIDTH+1)'(1);
    mag_half = mag_inc[WIDTH:1];
    mag_rc   = mag_half[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : mag_half;
    case (mode_i)
      MODE_MAG:      fmt_dat = {mag_rc, {WIDTH{1'b0}}};
      MODE_PHASE:    fmt_dat = {dat_i[WIDTH-1:0], {WIDTH{1'b0}}};
      MODE_MAGPHASE: fmt_dat = {mag_rc, dat_i[WIDTH-1:0]};
      default:       fmt_dat = '0;
    endcase
  end

  // Staging register next state: captures every beat this lane accepts.
  always_comb begin
    stage_vld_d = push_i;
    stage_dat_d = push_i ? {last_i, fmt_dat} : stage_dat_q;
  end

  // Staging register: its occupancy is counted against FIFO space, so it can always drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_vld_q <= 1'b0;
      stage_dat_q <= '0;
    end else begin
      stage_vld_q <= stage_vld_d;
      stage_dat_q <= stage_dat_d;
    end
  end

  magphase_fanout_fifo #(.W(2*WIDTH+1), .AW(DATA_AWIDTH)) u_dfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (stage_vld_q),
    .dat_i   (stage_dat_q),
    .pop_i   (dpop),
    .dat_o   (dhead),
    .full_o  (dfull_unused),
    .empty_o (dempty),
    .count_o (dcount)
  );

  magphase_fanout_fifo #(.W(HDR_W), .AW(HDR_AWIDTH)) u_hfifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_i & first_i),
    .dat_i   (munge_hdr(hdr_i, next_dst_i, 4'(LANE_IDX))),
    .pop_i   (hpop),
    .dat_o   (hhead),
    .full_o  (hfull),
    .empty_o (hempty),
    .count_o (hcount_unused)
  );

  assign dat_rdy_o = ((dcount + (DATA_AWIDTH+1)'(stage_vld_q)) != DDEPTH);
  assign hdr_rdy_o = !hfull;

  // Outputs are forced to zero while idle so nothing stale leaks out of the FIFO RAMs.
  assign tvalid_o = !dempty && !hempty;
  assign tdata_o  = tvalid_o ? dhead[2*WIDTH-1:0] : '0;
  assign tlast_o  = tvalid_o & dhead[2*WIDTH];
  assign tuser_o  = hempty ? '0 : hhead;
  assign dpop     = tvalid_o & tready_i;
  assign hpop     = dpop & dhead[2*WIDTH];

endmodule

// File: rtl/magphase_fanout.sv
// Purpose: fan one magnitude/phase CHDR stream out to NUM_OUT independently buffered lanes.
// Latency: two cycles from input acceptance to lane output valid.
// Backpressure: input accepted only when every enabled lane has room (lockstep); all-off drops.
module magphase_fanout
  import magphase_fanout_pkg::*;
#(
  parameter int NUM_OUT     = 2,
  parameter int WIDTH       = 16,
  parameter int DATA_AWIDTH = 5,
  parameter int HDR_AWIDTH  = 2,
  parameter int SR_BASE     = 128
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       set_stb,
  input  logic [7:0]                 set_addr,
  input  logic [31:0]                set_data,
  input  logic [2*WIDTH-1:0]         i_tdata,
  input  logic [127:0]               i_tuser,
  input  logic                       i_tlast,
  input  logic                       i_tvalid,
  output logic                       i_tready,
  output logic [NUM_OUT*2*WIDTH-1:0] o_tdata,
  output logic [NUM_OUT*128-1:0]     o_tuser,
  output logic [NUM_OUT-1:0]         o_tlast,
  output logic [NUM_OUT-1:0]         o_tvalid,
  input  logic [NUM_OUT-1:0]         o_tready,
  output logic [31:0]                drop_count
);

  logic [15:0]        next_dst_q    [NUM_OUT];
  logic [1:0]         mode_shadow_q [NUM_OUT];
  logic [1:0]         mode_active_q [NUM_OUT];
  logic [1:0]         eff_mode      [NUM_OUT];
  logic [NUM_OUT-1:0] lane_en, lane_dat_rdy, lane_hdr_rdy;
  logic               in_pkt_q, in_pkt_d;
  logic [31:0]        drop_count_q, drop_count_d;
  logic               init_q;
  logic               accept, all_off;
  logic               set_data_unused;

  assign set_data_unused = ^set_data[31:16];

  // Settings registers; writes land in the shadow, never directly in the active mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        next_dst_q[k]    <= '0;
        mode_shadow_q[k] <= (k == 0) ? MODE_MAG : (k == 1) ? MODE_PHASE : MODE_OFF;
        mode_active_q[k] <= (k == 0) ? MODE_MAG : (k == 1) ? MODE_PHASE : MODE_OFF;
      end
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (set_stb && set_addr == 8'(SR_BASE + SR_NEXT_DST_OFS + k)) next_dst_q[k] <= set_data[15:0];
        if (set_stb && set_addr == 8'(SR_BASE + SR_MODE_OFS + k))     mode_shadow_q[k] <= set_data[1:0];
        if (!in_pkt_q) mode_active_q[k] <= mode_shadow_q[k];
      end
    end
  end

  // Packet-tracking and drop-counter next state.
  always_comb begin
    in_pkt_d     = in_pkt_q;
    drop_count_d = drop_count_q;
    if (accept) begin
      in_pkt_d = !i_tlast;
      if (all_off && drop_count_q != '1) drop_count_d = drop_count_q + 32'd1;
    end
  end

  // Packet state, drop counter and the post-reset ready enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_pkt_q     <= 1'b0;
      drop_count_q <= '0;
      init_q       <= 1'b0;
    end else begin
      in_pkt_q     <= in_pkt_d;
      drop_count_q <= drop_count_d;
      init_q       <= 1'b1;
    end
  end

  // Between packets the shadow mode is used directly, so a first beat sees the shadow
  // as it stood before any same-cycle write; mid-packet the latched mode is frozen.
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    assign eff_mode[k] = in_pkt_q ? mode_active_q[k] : mode_shadow_q[k];
    assign lane_en[k]  = (eff_mode[k] != MODE_OFF);

    magphase_fanout_lane #(
      .WIDTH       (WIDTH),
      .DATA_AWIDTH (DATA_AWIDTH),
      .HDR_AWIDTH  (HDR_AWIDTH),
      .LANE_IDX    (k)
    ) u_lane (
      .clk        (clk),
      .rst_n      (reset_n),
      .mode_i     (eff_mode[k]),
      .next_dst_i (next_dst_q[k]),
      .push_i     (accept & lane_en[k]),
      .first_i    (!in_pkt_q),
      .dat_i      (i_tdata),
      .last_i     (i_tlast),
      .hdr_i      (i_tuser),
      .dat_rdy_o  (lane_dat_rdy[k]),
      .hdr_rdy_o  (lane_hdr_rdy[k]),
      .tdata_o    (o_tdata[k*2*WIDTH +: 2*WIDTH]),
      .tlast_o    (o_tlast[k]),
      .tvalid_o   (o_tvalid[k]),
      .tuser_o    (o_tuser[k*128 +: 128]),
      .tready_i   (o_tready[k])
    );
  end

  // Disabled lanes never hold the input back; with every lane off the reduction is 1.
  assign all_off    = ~|lane_en;
  assign i_tready   = init_q & (&(lane_dat_rdy | ~lane_en))
                             & (in_pkt_q | (&(lane_hdr_rdy | ~lane_en)));
  assign accept     = i_tvalid & i_tready;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_magphase_fanout.sv
// Purpose: scoreboard bench for magphase_fanout with directed packets on two lanes.
// Latency: expectations queued at issue time; per-lane monitor pops on each output handshake.
// Backpressure: exercised by stalling lane 1 until the input stalls.
module tb_magphase_fanout;

  localparam int N   = 2;
  localparam int W   = 16;
  localparam int SRB = 128;
  localparam int BOUND = 200;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             set_stb = 1'b0;
  logic [7:0]       set_addr = '0;
  logic [31:0]      set_data = '0;
  logic [2*W-1:0]   i_tdata = '0;
  logic [127:0]     i_tuser = '0;
  logic             i_tlast = 1'b0;
  logic             i_tvalid = 1'b0;
  logic             i_tready;
  logic [N*2*W-1:0] o_tdata;
  logic [N*128-1:0] o_tuser;
  logic [N-1:0]     o_tlast, o_tvalid;
  logic [N-1:0]     o_tready = '1;
  logic [31:0]      drop_count;

  always #5 clk = ~clk;

  magphase_fanout #(.NUM_OUT(N), .WIDTH(W), .DATA_AWIDTH(5), .HDR_AWIDTH(2), .SR_BASE(SRB)) dut (
    .clk(clk), .reset_n(reset_n), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .drop_count(drop_count)
  );

  typedef logic [160:0] beat_t;  // {tlast, tdata, tuser}
  beat_t exp_q0[$];
  beat_t exp_q1[$];

  int n_chk = 0, n_pass = 0;
  int n_acc = 0, n_stall = 0;
  int seen [N];
  logic [15:0] tb_dst  [N];
  logic [1:0]  tb_mode [N];

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [15:0] rc(input logic [15:0] m);
    logic [16:0] t;
    t = ({1'b0, m} + 17'd1) >> 1;
    return (t > 17'd32767) ? 16'h7FFF : t[15:0];
  endfunction

  function automatic logic [31:0] fmt(input logic [1:0] mode, input logic [31:0] d);
    case (mode)
      2'd0:    return {rc(d[31:16]), 16'h0000};
      2'd1:    return {d[15:0], 16'h0000};
      2'd2:    return {rc(d[31:16]), d[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [127:0] exp_hdr(input logic [127:0] u, input int k);
    return {u[127:96], u[79:68], 4'(k), tb_dst[k], u[63:0]};
  endfunction

  task automatic push_exp(input int k, input beat_t b);
    if (k == 0) exp_q0.push_back(b);
    else        exp_q1.push_back(b);
  endtask

  // Per-lane monitor: every output handshake pops and compares one expected beat.
  always @(negedge clk) begin
    beat_t got, e;
    for (int k = 0; k < N; k++) begin
      if (reset_n && o_tvalid[k] && o_tready[k]) begin
        got = {o_tlast[k], o_tdata[k*2*W +: 2*W], o_tuser[k*128 +: 128]};
        seen[k]++;
        if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
          n_chk++;
          $display("FAIL lane%0d unexpected beat: got %h expected none", k, got);
        end else begin
          if (k == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          chk($sformatf("lane%0d beat", k), 192'(got), 192'(e));
        end
      end
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l, input logic [127:0] u);
    int waited;
    bit ok;
    i_tvalid = 1'b1; i_tdata = d; i_tlast = l; i_tuser = u;
    waited = 0; ok = 1'b0;
    while (!ok && waited < BOUND) begin
      @(negedge clk);
      ok = i_tready;
      if (!ok) begin
        @(posedge clk); #1;
        waited++;
      end
    end
    if (ok) begin
      @(posedge clk); #1;
      n_acc++;
    end else begin
      n_chk++;
      $display("FAIL send_beat timeout: i_tready low for %0d cycles", waited);
    end
    if (waited != 0) n_stall++;
  endtask

  task automatic send_pkt(input int n, input logic [31:0] base, input logic [127:0] u,
                          input int wr_at, input logic [7:0] wa, input logic [31:0] wd);
    logic [31:0] d;
    for (int k = 0; k < N; k++) begin
      if (tb_mode[k] != 2'd3) begin
        for (int i = 0; i < n; i++) begin
          d = base + 32'(i) * 32'h0101_0203;
          push_exp(k, {i == n-1, fmt(tb_mode[k], d), exp_hdr(u, k)});
        end
      end
    end
    for (int i = 0; i < n; i++) begin
      if (i == wr_at) begin set_stb = 1'b1; set_addr = wa; set_data = wd; end
      send_beat(base + 32'(i) * 32'h0101_0203, i == n-1, u);
      set_stb = 1'b0;
    end
    i_tvalid = 1'b0; i_tlast = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 300; c++) begin
      if (exp_q0.size() == 0 && exp_q1.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk(name, 192'(exp_q0.size() + exp_q1.size()), 192'd0);
  endtask

  initial begin
    logic [127:0] u;
    logic [31:0]  vec_in  [3];
    logic [31:0]  vec_exp [3];
    int base_acc, base_seen0, base_stall;
    bit stalled, done;

    for (int k = 0; k < N; k++) begin
      seen[k] = 0; tb_dst[k] = 16'h0;
    end
    tb_mode[0] = 2'd0; tb_mode[1] = 2'd1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset o_tvalid", 192'(o_tvalid), 192'd0);
    chk("reset o_tdata", 192'(o_tdata), 192'd0);
    chk("reset o_tlast", 192'(o_tlast), 192'd0);
    chk("reset drop_count", 192'(drop_count), 192'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("i_tready after reset", 192'(i_tready), 192'd1);

    // Magnitude rounding on lane0 (MAG), lane1 (PHASE) carries phase 0x1234
    vec_in[0] = 32'h0003_1234; vec_exp[0] = 32'h0002_0000;
    vec_in[1] = 32'hFFFF_1234; vec_exp[1] = 32'h7FFF_0000;
    vec_in[2] = 32'h0000_1234; vec_exp[2] = 32'h0000_0000;
    u = {32'h1000_0001, 16'h0ABC, 16'h0777, 64'h0000_0000_1111_2222};
    for (int i = 0; i < 3; i++) begin
      push_exp(0, {1'b1, vec_exp[i], exp_hdr(u, 0)});
      push_exp(1, {1'b1, 32'h1234_0000, exp_hdr(u, 1)});
    end
    for (int i = 0; i < 3; i++) send_beat(vec_in[i], 1'b1, u);
    i_tvalid = 1'b0;
    drain("rounding drain");

    // Default modes, SID munge with next_dst 0x0040/0x0050, 4-beat packet
    wr(8'(SRB + 0), 32'h0000_0040); tb_dst[0] = 16'h0040;
    wr(8'(SRB + 1), 32'h0000_0050); tb_dst[1] = 16'h0050;
    u = {32'h2000_0004, 16'hBEEF, 16'h0123, 64'hDEAD_BEEF_0000_0010};
    chk("munge lane0 sid", 192'(exp_hdr(u, 0)),
        192'({32'h2000_0004, 16'h0120, 16'h0040, 64'hDEAD_BEEF_0000_0010}));
    send_pkt(4, 32'h8001_F00F, u, -1, 8'h0, 32'h0);
    drain("munge drain");

    // Backpressure: lane1 stalled, lane0 free
    o_tready = 2'b01;
    base_acc = n_acc; base_seen0 = seen[0]; done = 1'b0; stalled = 1'b0;
    u = {32'h3000_0028, 16'h1111, 16'h0450, 64'h0};
    fork
      begin send_pkt(40, 32'h0010_0020, u, -1, 8'h0, 32'h0); done = 1'b1; end
    join_none
    for (int c = 0; c < BOUND; c++) begin
      @(negedge clk);
      if (i_tvalid && !i_tready) begin stalled = 1'b1; break; end
    end
    chk("bp stall seen", 192'(stalled), 192'd1);
    chk("bp beats before stall", 192'(n_acc - base_acc), 192'd32);
    repeat (40) @(posedge clk);
    #1;
    chk("bp lane0 drained", 192'(seen[0] - base_seen0), 192'd32);
    chk("bp input still stalled", 192'(i_tready), 192'd0);
    o_tready = 2'b11;
    for (int c = 0; c < 400 && !done; c++) @(posedge clk);
    #1;
    chk("bp sender done", 192'(done), 192'd1);
    drain("bp drain");

    // Mode change mid-packet: lane0 stays MAG for this packet, PHASE for the next
    u = {32'h4000_0008, 16'h2222, 16'h0560, 64'h0};
    send_pkt(8, 32'h4000_2222, u, 2, 8'(SRB + 4), 32'd1);
    tb_mode[0] = 2'd1;
    send_pkt(2, 32'h6000_3333, u, -1, 8'h0, 32'h0);
    drain("mode change drain");

    // All lanes off: beats discarded and counted
    wr(8'(SRB + 4), 32'd3); wr(8'(SRB + 5), 32'd3);
    tb_mode[0] = 2'd3; tb_mode[1] = 2'd3;
    base_stall = n_stall;
    send_pkt(10, 32'h7000_0001, u, -1, 8'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("off no input stall", 192'(n_stall - base_stall), 192'd0);
    chk("off drop_count", 192'(drop_count), 192'd10);
    chk("off no o_tvalid", 192'(o_tvalid), 192'd0);

    // Asynchronous reset mid-packet
    wr(8'(SRB + 4), 32'd0); wr(8'(SRB + 5), 32'd2);
    o_tready = 2'b00;
    u = {32'h5000_0006, 16'h3333, 16'h0890, 64'h0};
    for (int i = 0; i < 3; i++) send_beat(32'h1000_0100 + 32'(i), 1'b0, u);
    i_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre-reset o_tvalid", 192'(o_tvalid), 192'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset o_tvalid", 192'(o_tvalid), 192'd0);
    chk("async reset o_tdata", 192'(o_tdata), 192'd0);
    chk("async reset drop_count", 192'(drop_count), 192'd0);
    exp_q0.delete(); exp_q1.delete();
    tb_mode[0] = 2'd0; tb_mode[1] = 2'd1;
    tb_dst[0] = 16'h0; tb_dst[1] = 16'h0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    o_tready = 2'b11;
    @(posedge clk); #1;
    chk("i_tready after mid-packet reset", 192'(i_tready), 192'd1);
    u = {32'h6000_0003, 16'h4444, 16'h0ACE, 64'h0123_4567_89AB_CDEF};
    send_pkt(3, 32'h9000_5555, u, -1, 8'h0, 32'h0);
    drain("post-reset drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
